// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, FSM encodings
// and the default number of device interrupt lines.
package int_ctrl_pkg;

  localparam int unsigned NIRQ_DEF = 6;
  localparam int unsigned IDX_W    = 3;

  localparam logic [31:0] OFF_MASK  = 32'h0000_0000;
  localparam logic [31:0] OFF_PEND  = 32'h0000_0004;
  localparam logic [31:0] OFF_MODE  = 32'h0000_0008;
  localparam logic [31:0] OFF_CLAIM = 32'h0000_000c;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_INSVC  = 2'd2;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of the eligible vector.
module int_prio_enc #(
  parameter int unsigned N  = 6,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  eligible,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: MASK/PEND/MODE/CLAIM registers, edge or level
// lines, lowest-index priority and a claim/EOI handshake towards the CPU.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_7f30,
  parameter int unsigned NIRQ = NIRQ_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     Addr,
  input  logic [31:0]     DataIn,
  input  logic            We,
  input  logic            Re,
  output logic [31:0]     DataOut,
  input  logic [NIRQ-1:0] IrqIn,
  output logic            IntReq
);

  logic [NIRQ-1:0]  mask_q, mask_d;
  logic [NIRQ-1:0]  mode_q, mode_d;
  logic [NIRQ-1:0]  pend_q, pend_d;
  logic [NIRQ-1:0]  irq_q, irq_d;
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] isr_q, isr_d;
  logic             int_req_q, int_req_d;

  logic             sel_mask, sel_pend, sel_mode, sel_claim;
  logic [NIRQ-1:0]  pend_view, eligible, clr;
  logic             win_valid;
  logic [IDX_W-1:0] win_idx;
  logic             claim_fire, eoi_hit;
  logic             unused_din;

  assign sel_mask  = (Addr == BASE + OFF_MASK);
  assign sel_pend  = (Addr == BASE + OFF_PEND);
  assign sel_mode  = (Addr == BASE + OFF_MODE);
  assign sel_claim = (Addr == BASE + OFF_CLAIM);
  assign unused_din = ^DataIn;

  // Edge lines report the latched bit, level lines the synchronised input.
  assign pend_view = (pend_q & mode_q) | (irq_q & ~mode_q);
  assign eligible  = pend_view & mask_q;

  int_prio_enc #(.N(NIRQ), .IW(IDX_W)) u_prio (
    .eligible (eligible),
    .valid    (win_valid),
    .idx      (win_idx)
  );

  // A write in the same cycle suppresses the claim side effects.
  assign claim_fire = Re & ~We & sel_claim & (state_q == ST_ACTIVE) & win_valid;
  assign eoi_hit    = We & sel_claim & (DataIn[IDX_W-1:0] == isr_q + IDX_W'(1));

  always_comb begin
    mask_d    = mask_q;
    mode_d    = mode_q;
    irq_d     = IrqIn;
    isr_d     = isr_q;
    state_d   = state_q;
    clr       = '0;

    if (We && sel_mask) mask_d = DataIn[NIRQ-1:0];
    if (We && sel_mode) begin
      mode_d = DataIn[NIRQ-1:0];
      clr    = clr | (DataIn[NIRQ-1:0] & ~mode_q);
    end
    if (We && sel_pend) clr = clr | DataIn[NIRQ-1:0];
    if (claim_fire) begin
      clr   = clr | (NIRQ'(1) << win_idx);
      isr_d = win_idx;
    end
    // Rising edges are OR-ed in last so a set beats any same-cycle clear.
    pend_d = (pend_q & ~clr) | (IrqIn & ~irq_q);

    case (state_q)
      ST_IDLE:   if (win_valid) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (claim_fire)      state_d = ST_INSVC;
        else if (!win_valid) state_d = ST_IDLE;
      end
      ST_INSVC:  if (eoi_hit) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    int_req_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q    <= '0;
      mode_q    <= '0;
      pend_q    <= '0;
      irq_q     <= '0;
      isr_q     <= '0;
      state_q   <= ST_IDLE;
      int_req_q <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      pend_q    <= pend_d;
      irq_q     <= irq_d;
      isr_q     <= isr_d;
      state_q   <= state_d;
      int_req_q <= int_req_d;
    end
  end

  // Read mux; reads are side-effect free apart from the claim handled above.
  always_comb begin
    DataOut = '0;
    if (sel_mask)       DataOut = 32'(mask_q);
    else if (sel_pend)  DataOut = 32'(pend_view);
    else if (sel_mode)  DataOut = 32'(mode_q);
    else if (sel_claim && win_valid) DataOut = 32'(win_idx) + 32'd1;
  end

  assign IntReq = int_req_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: directed scenarios plus random bus/IRQ traffic,
// checked against a transaction-level reference model.
module tb_int_ctrl;

  localparam logic [31:0] BASE    = 32'h0000_7f30;
  localparam int          NIRQ    = 6;
  localparam logic [31:0] A_MASK  = BASE;
  localparam logic [31:0] A_PEND  = BASE + 32'd4;
  localparam logic [31:0] A_MODE  = BASE + 32'd8;
  localparam logic [31:0] A_CLAIM = BASE + 32'd12;
  localparam logic [31:0] A_NONE  = BASE + 32'd16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [31:0]     Addr = 32'd0;
  logic [31:0]     DataIn = 32'd0;
  logic            We = 1'b0;
  logic            Re = 1'b0;
  logic [31:0]     DataOut;
  logic [NIRQ-1:0] IrqIn = '0;
  logic            IntReq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Reference model state: 0 idle, 1 active, 2 in service.
  logic [5:0] m_mask = '0, m_mode = '0, m_pend = '0, m_irq = '0;
  int         m_state = 0;
  int         m_isr = 0;
  logic       m_intreq = 1'b0;

  int_ctrl #(.BASE(BASE), .NIRQ(NIRQ)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .DataIn(DataIn), .We(We), .Re(Re),
    .DataOut(DataOut), .IrqIn(IrqIn), .IntReq(IntReq)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] eff_pend();
    logic [5:0] p;
    for (int i = 0; i < 6; i++) p[i] = m_mode[i] ? m_pend[i] : m_irq[i];
    return p;
  endfunction

  function automatic int winner(input logic [5:0] e);
    for (int i = 0; i < 6; i++) if (e[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int w;
    w = winner(eff_pend() & m_mask);
    if (a == A_MASK) return {26'd0, m_mask};
    if (a == A_PEND) return {26'd0, eff_pend()};
    if (a == A_MODE) return {26'd0, m_mode};
    if (a == A_CLAIM) return (w < 0) ? 32'd0 : 32'(w + 1);
    return 32'd0;
  endfunction

  always @(posedge clk) begin : ref_model
    logic [5:0] ep, clr;
    int w, ns;
    bit claim, eoi;
    if (reset) begin
      m_mask <= '0; m_mode <= '0; m_pend <= '0; m_irq <= '0;
      m_state <= 0; m_isr <= 0; m_intreq <= 1'b0;
    end else begin
      ep    = eff_pend();
      w     = winner(ep & m_mask);
      claim = Re && !We && Addr == A_CLAIM && m_state == 1 && w >= 0;
      eoi   = We && Addr == A_CLAIM && m_state == 2 && int'(DataIn[2:0]) == m_isr + 1;
      ns = m_state;
      case (m_state)
        0: if (w >= 0) ns = 1;
        1: if (claim) ns = 2; else if (w < 0) ns = 0;
        2: if (eoi) ns = 0;
        default: ns = 0;
      endcase
      clr = '0;
      if (We && Addr == A_PEND) clr = clr | DataIn[5:0];
      if (We && Addr == A_MODE) clr = clr | (DataIn[5:0] & ~m_mode);
      if (claim) clr[w] = 1'b1;
      m_pend <= (m_pend & ~clr) | (IrqIn & ~m_irq);
      if (claim) m_isr <= w;
      if (We && Addr == A_MASK) m_mask <= DataIn[5:0];
      if (We && Addr == A_MODE) m_mode <= DataIn[5:0];
      m_irq    <= IrqIn;
      m_state  <= ns;
      m_intreq <= (ns == 1);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: IntReq every cycle, read data whenever a load is presented.
  always @(negedge clk) begin
    chk("intreq_model", 32'(IntReq), 32'(m_intreq));
    if (Re) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_underflow got read with empty scoreboard at %0t", $time);
      end else begin
        chk("dataout", DataOut, exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    Addr = a; DataIn = d; We = 1'b1;
    cyc();
    We = 1'b0; Addr = 32'd0; DataIn = 32'd0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input bit use_c, input logic [31:0] c);
    Addr = a; Re = 1'b1;
    exp_q.push_back(use_c ? c : model_read(a));
    cyc();
    Re = 1'b0; Addr = 32'd0;
  endtask

  task automatic bus_both(input logic [31:0] a, input logic [31:0] d);
    Addr = a; DataIn = d; We = 1'b1; Re = 1'b1;
    exp_q.push_back(model_read(a));
    cyc();
    We = 1'b0; Re = 1'b0; Addr = 32'd0; DataIn = 32'd0;
  endtask

  task automatic pulse(input logic [5:0] v);
    IrqIn = v;
    cyc();
    IrqIn = '0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return A_MASK;
      1: return A_PEND;
      2: return A_MODE;
      3: return A_CLAIM;
      4: return BASE + 32'd2;
      default: return A_NONE;
    endcase
  endfunction

  initial begin
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_intreq", 32'(IntReq), 32'd0);
    bus_rd(A_MASK, 1, 32'd0);
    bus_rd(A_CLAIM, 1, 32'd0);

    // Edge line 0: claim, drop, EOI.
    bus_wr(A_MASK, 32'h3f);
    bus_wr(A_MODE, 32'h03);
    pulse(6'h01);
    chk("s1_intreq_early", 32'(IntReq), 32'd0);
    bus_rd(A_PEND, 1, 32'h01);
    chk("s1_intreq_on", 32'(IntReq), 32'd1);
    bus_rd(A_CLAIM, 1, 32'd1);
    chk("s1_intreq_off", 32'(IntReq), 32'd0);
    bus_wr(A_CLAIM, 32'd1);
    bus_rd(A_CLAIM, 1, 32'd0);
    bus_rd(A_PEND, 1, 32'd0);

    // Simultaneous edges on lines 1 and 3.
    bus_wr(A_MODE, 32'h3f);
    pulse(6'h0a);
    cyc();
    bus_rd(A_CLAIM, 1, 32'd2);
    bus_wr(A_CLAIM, 32'd2);
    cyc();
    chk("s2_reassert", 32'(IntReq), 32'd1);
    bus_rd(A_CLAIM, 1, 32'd4);
    bus_wr(A_CLAIM, 32'd4);

    // Mismatched EOI is ignored; new edges still latch while in service.
    pulse(6'h02);
    cyc();
    bus_rd(A_CLAIM, 1, 32'd2);
    bus_wr(A_CLAIM, 32'd5);
    cyc();
    chk("s4_insvc_hold", 32'(IntReq), 32'd0);
    pulse(6'h01);
    cyc(); cyc();
    chk("s4_insvc_quiet", 32'(IntReq), 32'd0);
    bus_rd(A_PEND, 1, 32'h01);
    bus_wr(A_CLAIM, 32'd2);
    cyc();
    chk("s4_after_eoi", 32'(IntReq), 32'd1);
    bus_rd(A_CLAIM, 1, 32'd1);
    bus_wr(A_CLAIM, 32'd1);

    // Edge on line 2 in the same cycle as its claim keeps it pending.
    pulse(6'h04);
    cyc();
    IrqIn = 6'h04;
    bus_rd(A_CLAIM, 1, 32'd3);
    IrqIn = '0;
    bus_rd(A_PEND, 1, 32'h04);
    bus_wr(A_CLAIM, 32'd3);
    cyc();
    chk("s5_reassert", 32'(IntReq), 32'd1);
    bus_rd(A_CLAIM, 1, 32'd3);
    bus_wr(A_CLAIM, 32'd3);
    bus_rd(A_PEND, 1, 32'd0);

    // Level line 4: masking drops IntReq, W1C leaves the level bit alone.
    bus_wr(A_MODE, 32'h00);
    bus_wr(A_MASK, 32'h10);
    IrqIn = 6'h10;
    cyc(); cyc();
    chk("s3_level_on", 32'(IntReq), 32'd1);
    bus_wr(A_PEND, 32'h10);
    bus_rd(A_PEND, 1, 32'h10);
    bus_wr(A_MASK, 32'h00);
    cyc();
    chk("s3_masked_off", 32'(IntReq), 32'd0);
    bus_rd(A_PEND, 1, 32'h10);
    bus_rd(A_NONE, 1, 32'd0);
    IrqIn = '0;
    cyc();

    // Reset while in service with PEND = 05.
    bus_wr(A_MODE, 32'h3f);
    bus_wr(A_MASK, 32'h3f);
    pulse(6'h05);
    cyc();
    bus_rd(A_CLAIM, 1, 32'd1);
    pulse(6'h01);
    cyc();
    bus_rd(A_PEND, 1, 32'h05);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("s6_rst_intreq", 32'(IntReq), 32'd0);
    bus_rd(A_MASK, 1, 32'd0);
    bus_rd(A_PEND, 1, 32'd0);
    bus_rd(A_MODE, 1, 32'd0);
    bus_rd(A_CLAIM, 1, 32'd0);

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) IrqIn = 6'($urandom);
      case ($urandom_range(0, 11))
        0:       bus_wr(A_MASK, $urandom);
        1:       bus_wr(A_MODE, $urandom);
        2:       bus_wr(A_PEND, $urandom);
        3, 4:    bus_wr(A_CLAIM, 32'($urandom_range(0, 7)));
        5, 6:    bus_rd(rand_addr(), 0, 32'd0);
        7, 8:    bus_rd(A_CLAIM, 0, 32'd0);
        9:       bus_wr(A_NONE, $urandom);
        10:      bus_both(A_CLAIM, 32'($urandom_range(0, 7)));
        default: cyc();
      endcase
    end
    IrqIn = '0;
    cyc(); cyc();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d leftover entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL have these parameters: BASE, default 32'h0000_7f30, register window base address; NIRQ, default 6, number of device interrupt lines.
REQ-002 The block SHALL have these ports, one per line, as name, direction, width, meaning:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- Addr  input  32  bus address.
- DataIn  input  32  bus write data.
- We  input  1  write strobe.
- Re  input  1  read strobe, one cycle per CPU load.
- DataOut  output  32  read data, combinational.
- IrqIn  input  NIRQ  device IntReq lines, timers at index 0 and 1.
- IntReq  output  1  registered request to CP0 HWInt.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.

Function
REQ-004 The block SHALL decode only full-address matches: BASE+0 MASK (rw, [5:0]); BASE+4 PEND (read; write-1-to-clear); BASE+8 MODE (rw, [5:0]; 1=edge, 0=level); BASE+C CLAIM (read claims; write is EOI).
REQ-005 The block SHALL read unmapped addresses, and all unused upper bits, as 0; writes to unmapped addresses SHALL have no effect.
REQ-006 The block SHALL register IrqIn into irq_q every cycle; rise[i] = IrqIn[i] & ~irq_q[i].
REQ-007 Edge-mode pending bits SHALL set on rise and clear on claim of that line or on W1C; set wins over a same-cycle clear.
REQ-008 Level-mode pending bits SHALL equal irq_q, and W1C SHALL have no effect on them.
REQ-009 Eligible = PEND & MASK; the winner SHALL be the lowest eligible index (line 0 highest priority).
REQ-010 The FSM SHALL have three states, IDLE, ACTIVE and INSVC, with these transitions:
- IDLE -> ACTIVE when eligible != 0.
- ACTIVE -> IDLE when eligible becomes 0 (mask or W1C).
- ACTIVE -> INSVC on a CLAIM read with Re.
- INSVC -> IDLE on an EOI write whose DataIn[2:0] equals the stored in-service index + 1.
REQ-011 IntReq SHALL be a register, 1 exactly while the FSM is in ACTIVE; it rises 1 cycle after an eligible pending bit appears, i.e. 2 cycles after the IrqIn edge.
REQ-012 A CLAIM read SHALL return {29'b0, winner+1}, or 0 when there is no winner; DataOut is valid in the same cycle as Re.
REQ-013 On claim in ACTIVE, the block SHALL store the winner index and clear its edge-mode pending bit at the clock edge.
REQ-014 A CLAIM read in IDLE or INSVC SHALL return the value defined in REQ-012, but state and in-service index SHALL be unchanged and no pending bit SHALL be cleared.
REQ-015 An EOI that does not match the in-service index, or arrives outside INSVC, SHALL be ignored.
REQ-016 While in INSVC, IntReq SHALL stay 0 and new edges SHALL still latch into PEND.
REQ-017 After EOI, if eligible != 0, the block SHALL go IDLE -> ACTIVE on the next cycle.
REQ-018 We and Re SHALL never be asserted together; if they are, We takes effect and the claim is suppressed.
REQ-019 A MODE write SHALL clear PEND bits for the lines switched to edge mode.

Reset
REQ-020 Reset SHALL set MASK=0, MODE=0, edge PEND=0, irq_q=0, FSM=IDLE, in-service index=0 and IntReq=0, in 1 cycle.
REQ-021 Reset SHALL take priority over every bus access, and reset during INSVC SHALL abandon the service without EOI.

Structure
REQ-022 A shared package SHALL hold the register offsets (0,4,8,C), the FSM state encodings and NIRQ.
REQ-023 The priority encoder SHALL be a single sub-module, int_prio_enc: NIRQ-bit eligible in; valid plus index out; purely combinational.

Verification
REQ-024 The bench SHALL cover these scenarios:
- MASK=6'h3F, MODE=6'h03, IrqIn[0] pulsed for 1 cycle -> PEND=1, IntReq=1 two cycles after the edge; CLAIM read returns 1; IntReq drops next cycle; EOI write of 1 -> IDLE.
- Edges on lines 1 and 3 in the same cycle -> claim returns 2; after EOI 2, IntReq re-asserts and claim returns 4.
- Level line 4 high, MASK=6'h10 -> IntReq=1; write MASK=0 -> IntReq=0 within 2 cycles; PEND[4] still reads 1.
- In INSVC, write EOI 5 while the in-service index is 1 -> state stays INSVC and IntReq stays 0; EOI 2 -> IDLE.
- Edge on line 2 in the same cycle as the claim of line 2 -> PEND[2] stays 1 and IntReq re-asserts after EOI.
- Reset asserted in INSVC with PEND=6'h05 -> all registers read 0, IntReq=0 and CLAIM reads 0.
